mem_initiator: RTL and testbench

Load/store initiator that drives the single-cycle-ack word memory port (`rd_en`/`wr_en`/`addr`/`data`/`ack`) on behalf of a core-side request interface. It sits between the CPU load/store path and the memory responder. It performs byte and halfword loads with sign or zero extension, and byte and halfword stores via read-modify-write. It also detects misaligned accesses and times out unanswered transactions.

---
 rtl/mem_initiator.sv | 187 ++++++++++++++++++
 tb/tb_mem_initiator.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_initiator.sv
// rtl/mem_initiator.sv - load/store initiator for a single-cycle-ack word memory port
module mem_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        mem_rd_en_o,
  output logic        mem_wr_en_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_ack_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE_RD, S_WAIT_RD, S_ISSUE_WR, S_WAIT_WR, S_RESP
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, uns_q;
  logic [1:0]  size_q, off_q;
  logic [15:0] wdata_q;
  logic        ready_q, rsp_valid_q, rsp_err_q, rd_en_q, wr_en_q;
  logic [31:0] rsp_rdata_q, addr_q, mdata_q;

  logic        accept, misalign, err_d;
  logic [31:0] rdata_d, wword_d, load_ext, merged;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign accept   = req_valid_i & ready_q;
  assign misalign = (req_size_i == 2'b11) |
                    ((req_size_i == 2'b01) & req_addr_i[0]) |
                    ((req_size_i == 2'b10) & (|req_addr_i[1:0]));

  // Lane extraction with extension for loads, lane merge for sub-word stores
  always_comb begin
    byte_sel = mem_data_i[7:0];
    merged   = mem_data_i;
    case (off_q)
      2'd0: byte_sel = mem_data_i[7:0];
      2'd1: byte_sel = mem_data_i[15:8];
      2'd2: byte_sel = mem_data_i[23:16];
      default: byte_sel = mem_data_i[31:24];
    endcase
    half_sel = off_q[1] ? mem_data_i[31:16] : mem_data_i[15:0];
    case (size_q)
      2'b00:   load_ext = {{24{~uns_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = {{16{~uns_q & half_sel[15]}}, half_sel};
      default: load_ext = mem_data_i;
    endcase
    if (size_q == 2'b00) begin
      case (off_q)
        2'd0: merged[7:0]   = wdata_q[7:0];
        2'd1: merged[15:8]  = wdata_q[7:0];
        2'd2: merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (off_q[1]) begin
      merged[31:16] = wdata_q;
    end else begin
      merged[15:0] = wdata_q;
    end
  end

  // Next-state logic plus the values loaded into the registered outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    rdata_d = 32'd0;
    wword_d = mdata_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (misalign) begin
            state_d = S_RESP;
            err_d   = 1'b1;
          end else if (req_we_i && req_size_i == 2'b10) begin
            state_d = S_ISSUE_WR;
            wword_d = req_wdata_i;
          end else begin
            state_d = S_ISSUE_RD;
          end
        end
      end
      S_ISSUE_RD: begin
        state_d = S_WAIT_RD;
        cnt_d   = 8'd0;
      end
      S_WAIT_RD: begin
        if (mem_ack_i) begin
          if (we_q) begin
            state_d = S_ISSUE_WR;
            wword_d = merged;
          end else begin
            state_d = S_RESP;
            rdata_d = load_ext;
          end
        end else if (cnt_q == TO_LAST) begin
          state_d = S_RESP;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_ISSUE_WR: begin
        state_d = S_WAIT_WR;
        cnt_d   = 8'd0;
      end
      S_WAIT_WR: begin
        if (mem_ack_i) begin
          state_d = S_RESP;
        end else if (cnt_q == TO_LAST) begin
          state_d = S_RESP;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, request latch and registered outputs decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      size_q      <= 2'b00;
      off_q       <= 2'b00;
      wdata_q     <= 16'd0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      addr_q      <= 32'd0;
      mdata_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= (state_d == S_IDLE);
      rd_en_q     <= (state_d == S_ISSUE_RD);
      wr_en_q     <= (state_d == S_ISSUE_WR);
      rsp_valid_q <= (state_d == S_RESP);
      rsp_err_q   <= err_d;
      rsp_rdata_q <= rdata_d;
      mdata_q     <= wword_d;
      if (accept) begin
        we_q    <= req_we_i;
        uns_q   <= req_unsigned_i;
        size_q  <= req_size_i;
        off_q   <= req_addr_i[1:0];
        wdata_q <= req_wdata_i[15:0];
        addr_q  <= {req_addr_i[31:2], 2'b00};
      end
    end
  end

  assign req_ready_o = ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign mem_rd_en_o = rd_en_q;
  assign mem_wr_en_o = wr_en_q;
  assign mem_addr_o  = addr_q;
  assign mem_data_o  = mdata_q;

endmodule

// File: tb/tb_mem_initiator.sv
// tb/tb_mem_initiator.sv - directed self-checking bench for mem_initiator
module tb_mem_initiator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [1:0]  req_size_i = 2'b00;
  logic        req_unsigned_i = 1'b0;
  logic [31:0] req_addr_i = 32'd0;
  logic [31:0] req_wdata_i = 32'd0;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        mem_rd_en_o;
  logic        mem_wr_en_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [31:0] mem_data_i;
  logic        mem_ack_i;

  logic        resp_en = 1'b1;
  logic        inj_ack = 1'b0;
  logic        mem_init = 1'b1;
  logic        ack_q = 1'b0;
  logic [31:0] rd_q = 32'd0;
  logic [31:0] mem [0:63];

  int checks = 0;
  int failures = 0;

  int          rd_cyc, wr_cyc, rd_cnt, wr_cnt, both_cnt, rsp_cyc, wait_cyc;
  logic [31:0] rd_addr, wr_data, got_rdata;
  logic        got_err;

  mem_initiator #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_size_i(req_size_i),
    .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .mem_rd_en_o(mem_rd_en_o), .mem_wr_en_o(mem_wr_en_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk = ~clk;

  // Responder: ack one cycle after a sampled enable, read data only in the ack cycle
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
      mem[4] <= 32'h8899AABB;
      ack_q  <= 1'b0;
    end else begin
      ack_q <= resp_en & (mem_rd_en_o | mem_wr_en_o);
      if (mem_rd_en_o) rd_q <= mem[mem_addr_o[7:2]];
      if (mem_wr_en_o && resp_en) mem[mem_addr_o[7:2]] <= mem_data_o;
    end
  end

  assign mem_ack_i  = ack_q | inj_ack;
  assign mem_data_i = ack_q ? rd_q : 32'hDEADBEEF;

  task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
    wait_cyc = 0;
    while (!req_ready_o && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (!req_ready_o) begin
      checks++;
      failures++;
      $display("FAIL ready_wait req_ready_o=%0b required=1", req_ready_o);
    end
    req_valid_i = 1'b1;
    req_we_i = we;
    req_size_i = size;
    req_unsigned_i = uns;
    req_addr_i = addr;
    req_wdata_i = wdata;
    rd_cyc = -1; wr_cyc = -1; rd_cnt = 0; wr_cnt = 0; both_cnt = 0; rsp_cyc = -1;
    rd_addr = 32'd0; wr_data = 32'd0; got_rdata = 32'd0; got_err = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) req_valid_i = 1'b0;
      if (mem_rd_en_o && mem_wr_en_o) both_cnt++;
      if (mem_rd_en_o) begin
        rd_cnt++;
        if (rd_cyc < 0) begin rd_cyc = k; rd_addr = mem_addr_o; end
      end
      if (mem_wr_en_o) begin
        wr_cnt++;
        if (wr_cyc < 0) begin wr_cyc = k; wr_data = mem_data_o; end
      end
      if (rsp_valid_o) begin
        rsp_cyc = k;
        got_rdata = rsp_rdata_o;
        got_err = rsp_err_o;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready_o, rsp_valid_o, rsp_err_o, mem_rd_en_o, mem_wr_en_o} !== 5'b0 ||
        rsp_rdata_o !== 32'd0 || mem_addr_o !== 32'd0 || mem_data_o !== 32'd0) begin
      failures++;
      $display("FAIL reset_outputs ready=%0b vld=%0b err=%0b rd=%0b wr=%0b rdata=%h addr=%h data=%h required all 0",
               req_ready_o, rsp_valid_o, rsp_err_o, mem_rd_en_o, mem_wr_en_o, rsp_rdata_o, mem_addr_o, mem_data_o);
    end
    mem_init = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready got=%0b required=1", req_ready_o);
    end
  endtask

  task automatic test_load_word;
    run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
    checks++;
    if (rd_cyc !== 1 || rd_cnt !== 1 || wr_cnt !== 0) begin
      failures++;
      $display("FAIL load_word_enables rd_cyc=%0d rd_cnt=%0d wr_cnt=%0d required 1 1 0", rd_cyc, rd_cnt, wr_cnt);
    end
    checks++;
    if (rd_addr !== 32'h10) begin
      failures++;
      $display("FAIL load_word_addr got=%h required=00000010", rd_addr);
    end
    checks++;
    if (rsp_cyc !== 3 || got_rdata !== 32'h8899AABB || got_err !== 1'b0) begin
      failures++;
      $display("FAIL load_word_rsp cyc=%0d rdata=%h err=%0b required 3 8899aabb 0", rsp_cyc, got_rdata, got_err);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL load_word_after vld=%0b ready=%0b required 0 1", rsp_valid_o, req_ready_o);
    end
  endtask

  task automatic test_subword_loads;
    logic [31:0] addrs [4] = '{32'h13, 32'h12, 32'h12, 32'h10};
    logic [1:0]  sizes [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
    logic        unss  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] exps  [4] = '{32'hFFFFFF88, 32'h00000099, 32'hFFFF8899, 32'h0000AABB};
    for (int i = 0; i < 4; i++) begin
      run_req(1'b0, sizes[i], unss[i], addrs[i], 32'd0);
      checks++;
      if (rsp_cyc !== 3 || got_rdata !== exps[i] || got_err !== 1'b0 || wr_cnt !== 0) begin
        failures++;
        $display("FAIL subword_load[%0d] cyc=%0d rdata=%h err=%0b wr=%0d required 3 %h 0 0",
                 i, rsp_cyc, got_rdata, got_err, wr_cnt, exps[i]);
      end
    end
  endtask

  task automatic test_store_byte;
    run_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000CC);
    checks++;
    if (rd_cyc !== 1 || rd_cnt !== 1 || wr_cyc !== 3 || wr_cnt !== 1 || both_cnt !== 0) begin
      failures++;
      $display("FAIL store_byte_seq rd_cyc=%0d rd_cnt=%0d wr_cyc=%0d wr_cnt=%0d both=%0d required 1 1 3 1 0",
               rd_cyc, rd_cnt, wr_cyc, wr_cnt, both_cnt);
    end
    checks++;
    if (wr_data !== 32'h8899CCBB) begin
      failures++;
      $display("FAIL store_byte_wdata got=%h required=8899ccbb", wr_data);
    end
    checks++;
    if (rsp_cyc !== 5 || got_rdata !== 32'd0 || got_err !== 1'b0) begin
      failures++;
      $display("FAIL store_byte_rsp cyc=%0d rdata=%h err=%0b required 5 0 0", rsp_cyc, got_rdata, got_err);
    end
    run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
    checks++;
    if (got_rdata !== 32'h8899CCBB) begin
      failures++;
      $display("FAIL store_byte_readback got=%h required=8899ccbb", got_rdata);
    end
  endtask

  task automatic test_store_word;
    run_req(1'b1, 2'b10, 1'b0, 32'h14, 32'h12345678);
    checks++;
    if (rd_cnt !== 0 || wr_cyc !== 1 || wr_cnt !== 1 || wr_data !== 32'h12345678 || rsp_cyc !== 3 || got_err !== 1'b0) begin
      failures++;
      $display("FAIL store_word rd=%0d wr_cyc=%0d wr_cnt=%0d data=%h rsp=%0d err=%0b required 0 1 1 12345678 3 0",
               rd_cnt, wr_cyc, wr_cnt, wr_data, rsp_cyc, got_err);
    end
    run_req(1'b0, 2'b01, 1'b1, 32'h16, 32'd0);
    checks++;
    if (got_rdata !== 32'h00001234) begin
      failures++;
      $display("FAIL store_word_readback got=%h required=00001234", got_rdata);
    end
  endtask

  task automatic test_misaligned;
    logic        wes   [3] = '{1'b0, 1'b1, 1'b0};
    logic [1:0]  sizes [3] = '{2'b10, 2'b01, 2'b11};
    logic [31:0] addrs [3] = '{32'h12, 32'h11, 32'h10};
    for (int i = 0; i < 3; i++) begin
      run_req(wes[i], sizes[i], 1'b0, addrs[i], 32'h0000FFFF);
      checks++;
      if (rd_cnt !== 0 || wr_cnt !== 0 || rsp_cyc !== 1 || got_err !== 1'b1 || got_rdata !== 32'd0) begin
        failures++;
        $display("FAIL misaligned[%0d] rd=%0d wr=%0d cyc=%0d err=%0b rdata=%h required 0 0 1 1 0",
                 i, rd_cnt, wr_cnt, rsp_cyc, got_err, got_rdata);
      end
    end
  endtask

  task automatic test_back_to_back;
    run_req(1'b0, 2'b00, 1'b1, 32'h10, 32'd0);
    run_req(1'b0, 2'b00, 1'b1, 32'h11, 32'd0);
    checks++;
    if (wait_cyc !== 1 || rsp_cyc !== 3 || got_rdata !== 32'h000000CC) begin
      failures++;
      $display("FAIL back_to_back gap=%0d cyc=%0d rdata=%h required 1 3 000000cc", wait_cyc, rsp_cyc, got_rdata);
    end
  endtask

  task automatic test_timeout;
    resp_en = 1'b0;
    run_req(1'b0, 2'b10, 1'b0, 32'h20, 32'd0);
    checks++;
    if (rd_cyc !== 1 || rd_cnt !== 1 || rsp_cyc !== 6 || got_err !== 1'b1 || got_rdata !== 32'd0) begin
      failures++;
      $display("FAIL timeout_load rd_cyc=%0d rd_cnt=%0d cyc=%0d err=%0b rdata=%h required 1 1 6 1 0",
               rd_cyc, rd_cnt, rsp_cyc, got_err, got_rdata);
    end
    inj_ack = 1'b1;
    @(negedge clk);
    inj_ack = 1'b0;
    checks++;
    if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL timeout_ready ready=%0b vld=%0b required 1 0", req_ready_o, rsp_valid_o);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid_o !== 1'b0 || mem_rd_en_o !== 1'b0 || mem_wr_en_o !== 1'b0 || req_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL late_ack_ignored vld=%0b rd=%0b wr=%0b ready=%0b required 0 0 0 1",
               rsp_valid_o, mem_rd_en_o, mem_wr_en_o, req_ready_o);
    end
    run_req(1'b1, 2'b00, 1'b0, 32'h24, 32'h000000AA);
    checks++;
    if (wr_cnt !== 0 || rsp_cyc !== 6 || got_err !== 1'b1) begin
      failures++;
      $display("FAIL timeout_store wr=%0d cyc=%0d err=%0b required 0 6 1", wr_cnt, rsp_cyc, got_err);
    end
    resp_en = 1'b1;
  endtask

  task automatic test_reset_mid_rmw;
    int wr_seen;
    wr_seen = 0;
    @(negedge clk);
    req_valid_i = 1'b1;
    req_we_i = 1'b1;
    req_size_i = 2'b00;
    req_unsigned_i = 1'b0;
    req_addr_i = 32'h10;
    req_wdata_i = 32'h00000055;
    @(negedge clk);
    req_valid_i = 1'b0;
    checks++;
    if (mem_rd_en_o !== 1'b1) begin
      failures++;
      $display("FAIL rmw_rst_read rd=%0b required=1", mem_rd_en_o);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    if (mem_wr_en_o) wr_seen++;
    checks++;
    if ({req_ready_o, rsp_valid_o, rsp_err_o, mem_rd_en_o, mem_wr_en_o} !== 5'b0 ||
        rsp_rdata_o !== 32'd0 || mem_addr_o !== 32'd0 || mem_data_o !== 32'd0) begin
      failures++;
      $display("FAIL rmw_rst_outputs ready=%0b vld=%0b err=%0b rd=%0b wr=%0b rdata=%h addr=%h data=%h required all 0",
               req_ready_o, rsp_valid_o, rsp_err_o, mem_rd_en_o, mem_wr_en_o, rsp_rdata_o, mem_addr_o, mem_data_o);
    end
    rst = 1'b0;
    @(negedge clk);
    if (mem_wr_en_o) wr_seen++;
    checks++;
    if (req_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL rmw_rst_ready got=%0b required=1", req_ready_o);
    end
    repeat (3) begin
      @(negedge clk);
      if (mem_wr_en_o) wr_seen++;
    end
    checks++;
    if (wr_seen !== 0) begin
      failures++;
      $display("FAIL rmw_rst_no_write wr_pulses=%0d required=0", wr_seen);
    end
    run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
    checks++;
    if (got_rdata !== 32'h8899CCBB || got_err !== 1'b0) begin
      failures++;
      $display("FAIL rmw_rst_mem got=%h err=%0b required 8899ccbb 0", got_rdata, got_err);
    end
  endtask

  initial begin
    test_reset;
    test_load_word;
    test_subword_loads;
    test_store_byte;
    test_store_word;
    test_misaligned;
    test_back_to_back;
    test_timeout;
    test_reset_mid_rmw;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
